// File: rtl/matvec_pkg.sv
// Shared types and arithmetic helpers for the streaming matrix-vector engine.
// Holds the job state encoding and the scale/narrow rule applied to every result.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int accw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Floor-shift then clamp or wrap; the caller keeps the low dw bits.
    function automatic logic signed [63:0] narrow(
        input logic signed [63:0] sum,
        input int                 shift,
        input bit                 sat,
        input int                 dw
    );
        logic signed [63:0] sh;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        sh   = sum >>> shift;
        maxv = (64'sd1 <<< (dw - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (dw - 1));
        if (sat && (sh > maxv)) begin
            return maxv;
        end else if (sat && (sh < minv)) begin
            return minv;
        end
        return sh;
    endfunction

endpackage

// File: rtl/matvec_dot.sv
// Two-stage dot product: N signed multipliers, then adder tree plus narrowing.
// Latency 2 cycles from in_valid to out_valid.
// Backpressure: every register (data, valid, tag) holds while en is low.
module matvec_dot
    import matvec_pkg::*;
#(
    parameter int N     = 16,
    parameter int DW    = 8,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [$clog2(N)-1:0]  in_row,
    input  logic                  in_last,
    input  logic [N*DW-1:0]       row_data,
    input  logic [N*DW-1:0]       vec_data,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_last
);
    localparam int ACCW = accw(DW, N);
    localparam int RW   = $clog2(N);
    localparam int PW   = 2 * DW;

    typedef struct packed {
        logic          last;
        logic [RW-1:0] row;
    } tag_t;

    logic signed [PW-1:0] a_ext [N];
    logic signed [PW-1:0] b_ext [N];
    logic signed [PW-1:0] prod_q [N];
    logic                 s1_vld_q;
    tag_t                 s1_tag_q;
    logic                 s2_vld_q;
    tag_t                 s2_tag_q;
    logic [DW-1:0]        res_q;
    logic signed [ACCW-1:0] sum;
    logic signed [63:0]   scaled;
    logic                 unused_hi;

    // Operands are widened first so the multiply is evaluated at product width.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            a_ext[j] = {{DW{row_data[j*DW+DW-1]}}, row_data[j*DW +: DW]};
            b_ext[j] = {{DW{vec_data[j*DW+DW-1]}}, vec_data[j*DW +: DW]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_tag_q <= '0;
            for (int j = 0; j < N; j++) begin
                prod_q[j] <= '0;
            end
        end else if (en) begin
            s1_vld_q <= in_valid;
            s1_tag_q <= '{last: in_last, row: in_row};
            for (int j = 0; j < N; j++) begin
                prod_q[j] <= a_ext[j] * b_ext[j];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < N; j++) begin
            sum = sum + {{(ACCW-PW){prod_q[j][PW-1]}}, prod_q[j]};
        end
    end

    assign scaled    = narrow({{(64-ACCW){sum[ACCW-1]}}, sum}, SHIFT, SAT != 0, DW);
    assign unused_hi = ^scaled[63:DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld_q <= 1'b0;
            s2_tag_q <= '0;
            res_q    <= '0;
        end else if (en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_tag_q <= s1_tag_q;
                res_q    <= scaled[DW-1:0];
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = res_q;
    assign out_row   = s2_tag_q.row;
    assign out_last  = s2_tag_q.last;

endmodule

// File: rtl/matvec_stream_engine.sv
// Streaming C = A*B: vector loaded once per job, then N rows give N results.
// Latency 2 cycles row-to-result, 1 row/cycle; a stalled result freezes the pipe
// and drops row_ready, so at most 2 rows are ever in flight.
module matvec_stream_engine
    import matvec_pkg::*;
#(
    parameter int N     = 16,
    parameter int DW    = 8,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vec_valid,
    input  logic [N*DW-1:0]       vec_data,
    output logic                  vec_ready,
    input  logic                  row_valid,
    input  logic [N*DW-1:0]       row_data,
    output logic                  row_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  done
);
    localparam int RW = $clog2(N);

    state_t          state_q;
    state_t          state_d;
    logic [N*DW-1:0] vec_q;
    logic [RW-1:0]   row_cnt_q;
    logic            stage_en;
    logic            vec_hs;
    logic            row_hs;
    logic            row_is_last;

    assign stage_en    = !(out_valid && !out_ready);
    assign vec_hs      = vec_valid && vec_ready;
    assign row_hs      = row_valid && row_ready;
    assign row_is_last = (row_cnt_q == RW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_ready = 1'b0;
        row_ready = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                vec_ready = 1'b1;
                if (vec_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                row_ready = stage_en;
                if (row_valid && stage_en && row_is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q     <= '0;
            row_cnt_q <= '0;
        end else if (vec_hs) begin
            vec_q     <= vec_data;
            row_cnt_q <= '0;
        end else if (row_hs) begin
            row_cnt_q <= row_cnt_q + 1'b1;
        end
    end

    matvec_dot #(
        .N     (N),
        .DW    (DW),
        .SHIFT (SHIFT),
        .SAT   (SAT)
    ) u_dot (
        .clk       (clk),
        .reset     (reset),
        .en        (stage_en),
        .in_valid  (row_hs),
        .in_row    (row_cnt_q),
        .in_last   (row_is_last),
        .row_data  (row_data),
        .vec_data  (vec_q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_matvec_stream_engine.sv
// Bench for matvec_stream_engine: three parameterisations share one stimulus stream
// and are scored against an arithmetic reference of C[i] = sum_j A[i][j]*B[j].
module tb_matvec_stream_engine;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int RW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            vec_valid = 1'b0;
    logic [N*DW-1:0] vec_data = '0;
    logic            row_valid = 1'b0;
    logic [N*DW-1:0] row_data = '0;
    logic            out_ready = 1'b1;
    logic            vec_ready, row_ready, out_valid, out_last, done;
    logic [DW-1:0]   out_data;
    logic [RW-1:0]   out_row;
    logic [DW-1:0]   od_t, od_s;
    logic            unused_vr_t, unused_rr_t, unused_ov_t, unused_ol_t, unused_dn_t;
    logic            unused_vr_s, unused_rr_s, unused_ov_s, unused_ol_s, unused_dn_s;
    logic [RW-1:0]   unused_or_t, unused_or_s;

    always #5 clk = ~clk;

    matvec_stream_engine #(.N(N), .DW(DW), .SHIFT(0), .SAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .out_ready(out_ready), .done(done));

    matvec_stream_engine #(.N(N), .DW(DW), .SHIFT(0), .SAT(0)) u_trunc (
        .clk(clk), .reset(reset),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(unused_vr_t),
        .row_valid(row_valid), .row_data(row_data), .row_ready(unused_rr_t),
        .out_valid(unused_ov_t), .out_data(od_t), .out_row(unused_or_t),
        .out_last(unused_ol_t), .out_ready(out_ready), .done(unused_dn_t));

    matvec_stream_engine #(.N(N), .DW(DW), .SHIFT(4), .SAT(1)) u_shift (
        .clk(clk), .reset(reset),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(unused_vr_s),
        .row_valid(row_valid), .row_data(row_data), .row_ready(unused_rr_s),
        .out_valid(unused_ov_s), .out_data(od_s), .out_row(unused_or_s),
        .out_last(unused_ol_s), .out_ready(out_ready), .done(unused_dn_s));

    int checks = 0;
    int failures = 0;
    int A [N][N];
    int B [N];
    int got_d [N];
    int got_t [N];
    int got_s [N];
    int got_row [N];
    int n_got, first_lat, done_lat, done_abs;

    // Reference narrowing: floor division by 2^shift, then clamp or wrap to 8 bits.
    function automatic int ref_out(input longint sum, input int shift, input bit sat);
        longint p, q;
        p = longint'(1) << shift;
        q = sum / p;
        if ((sum % p) != 0 && sum < 0) q = q - 1;
        if (sat) begin
            if (q > 127) q = 127;
            if (q < -128) q = -128;
        end else begin
            q = q % 256;
            if (q < 0) q = q + 256;
            if (q > 127) q = q - 256;
        end
        return int'(q);
    endfunction

    task automatic run_job(input int ready_mode, input int rowv_pct, input bit hold_vec,
                           input int abort_row);
        logic [N*DW-1:0] bvec, rvec;
        longint exp_sum [$];
        int     exp_row [$];
        int cyc, next_row, accepted, first_hs, last_hs, first_out, done_cyc, e_row;
        longint s, e_sum;
        bit prev_stall, aborted, exp_rr;
        logic [DW-1:0] prev_d;
        logic [RW-1:0] prev_r;
        n_got = 0; first_lat = -1; done_lat = -1; done_abs = -1;
        first_hs = -1; last_hs = -1; first_out = -1; done_cyc = -1;
        rvec = '0;
        for (int j = 0; j < N; j++) bvec[j*DW +: DW] = DW'(B[j]);
        @(negedge clk);
        vec_valid = 1'b1; vec_data = bvec; row_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (vec_ready !== 1'b1) begin
            failures++; $display("FAIL vec_ready_idle got=%b exp=1", vec_ready);
        end
        @(posedge clk);
        #1;
        vec_valid = hold_vec; vec_data = ~bvec;
        cyc = 0; next_row = 0; accepted = 0; prev_stall = 0; aborted = 0;
        prev_d = '0; prev_r = '0;
        while (accepted < N && !aborted && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (next_row < N && int'($urandom_range(99)) < rowv_pct) begin
                for (int j = 0; j < N; j++) rvec[j*DW +: DW] = DW'(A[next_row][j]);
                row_valid = 1'b1; row_data = rvec;
            end else begin
                row_valid = 1'b0;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(99) < 60);
                default: out_ready = !(cyc >= 8 && cyc < 13);
            endcase
            #1;
            checks++;
            if (vec_ready !== 1'b0) begin
                failures++; $display("FAIL vec_ready_busy cyc=%0d got=%b exp=0", cyc, vec_ready);
            end
            exp_rr = (next_row < N) && !(out_valid && !out_ready);
            checks++;
            if (row_ready !== exp_rr) begin
                failures++; $display("FAIL row_ready cyc=%0d got=%b exp=%b", cyc, row_ready, exp_rr);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_row !== prev_r) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d exp=1/%h/%0d",
                             cyc, out_valid, out_data, out_row, prev_d, prev_r);
                end
            end
            prev_stall = out_valid && !out_ready; prev_d = out_data; prev_r = out_row;
            if (row_valid && row_ready) begin
                s = 0;
                for (int j = 0; j < N; j++) s += longint'(A[next_row][j]) * longint'(B[j]);
                exp_sum.push_back(s); exp_row.push_back(next_row);
                if (first_hs < 0) first_hs = cyc;
                if (next_row == N - 1) last_hs = cyc;
                if (next_row == abort_row) aborted = 1;
                next_row++;
            end
            if (out_valid === 1'b1 && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                if (exp_row.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out cyc=%0d row=%0d exp=none", cyc, out_row);
                end else begin
                    e_row = exp_row.pop_front(); e_sum = exp_sum.pop_front();
                    checks++;
                    if (out_row !== RW'(e_row)) begin
                        failures++; $display("FAIL out_row got=%0d exp=%0d", out_row, e_row);
                    end
                    checks++;
                    if (out_data !== DW'(ref_out(e_sum, 0, 1))) begin
                        failures++; $display("FAIL data_sat row=%0d got=%h exp=%h", e_row, out_data,
                                             DW'(ref_out(e_sum, 0, 1)));
                    end
                    checks++;
                    if (od_t !== DW'(ref_out(e_sum, 0, 0))) begin
                        failures++; $display("FAIL data_trunc row=%0d got=%h exp=%h", e_row, od_t,
                                             DW'(ref_out(e_sum, 0, 0)));
                    end
                    checks++;
                    if (od_s !== DW'(ref_out(e_sum, 4, 1))) begin
                        failures++; $display("FAIL data_shift row=%0d got=%h exp=%h", e_row, od_s,
                                             DW'(ref_out(e_sum, 4, 1)));
                    end
                    checks++;
                    if (out_last !== (e_row == N - 1)) begin
                        failures++; $display("FAIL out_last row=%0d got=%b", e_row, out_last);
                    end
                    checks++;
                    if (done !== (e_row == N - 1)) begin
                        failures++; $display("FAIL done_on_accept row=%0d got=%b", e_row, done);
                    end
                    if (done === 1'b1) done_cyc = cyc;
                    got_d[n_got] = int'($signed(out_data));
                    got_t[n_got] = int'($signed(od_t));
                    got_s[n_got] = int'($signed(od_s));
                    got_row[n_got] = int'(out_row);
                    n_got++;
                end
                accepted++;
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    failures++; $display("FAIL done_spurious cyc=%0d got=%b exp=0", cyc, done);
                end
            end
        end
        vec_valid = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0) begin
                failures++; $display("FAIL abort_outputs got valid=%b done=%b exp=0/0", out_valid, done);
            end
            checks++;
            if (vec_ready !== 1'b1 || row_ready !== 1'b0) begin
                failures++; $display("FAIL abort_idle got vr=%b rr=%b exp=1/0", vec_ready, row_ready);
            end
            row_valid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
        end else begin
            checks++;
            if (accepted != N || exp_row.size() != 0 || next_row != N) begin
                failures++;
                $display("FAIL job_complete cyc=%0d results=%0d rows=%0d exp=%0d", cyc, accepted,
                         next_row, N);
            end
            first_lat = first_out - first_hs;
            done_lat  = done_cyc - last_hs;
            done_abs  = done_cyc;
            @(negedge clk);
            row_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if (vec_ready !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL idle_after_done got vr=%b done=%b exp=1/0", vec_ready, done);
            end
        end
    endtask

    task automatic randomize_job;
        for (int i = 0; i < N; i++) begin
            B[i] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < N; j++) A[i][j] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags got %b%b%b exp=000", out_valid, out_last, done);
        end
        checks++;
        if (out_data !== '0 || out_row !== '0) begin
            failures++; $display("FAIL reset_data got %h/%0d exp=0/0", out_data, out_row);
        end
        checks++;
        if (vec_ready !== 1'b1 || row_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got vr=%b rr=%b exp=1/0", vec_ready, row_ready);
        end
        checks++;
        if (u_dut.vec_q !== '0) begin
            failures++; $display("FAIL reset_vector got=%h exp=0", u_dut.vec_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity;
        for (int i = 0; i < N; i++) begin
            B[i] = i + 1;
            for (int j = 0; j < N; j++) A[i][j] = (i == j) ? 1 : 0;
        end
        run_job(0, 100, 1'b0, -1);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got_d[k] !== k + 1 || got_row[k] !== k) begin
                failures++;
                $display("FAIL identity[%0d] got=%0d/row%0d exp=%0d/row%0d", k, got_d[k], got_row[k],
                         k + 1, k);
            end
        end
        checks++;
        if (first_lat !== 2 || done_lat !== 2) begin
            failures++; $display("FAIL latency got first=%0d done=%0d exp=2/2", first_lat, done_lat);
        end
        checks++;
        if (done_abs !== N + 2) begin
            failures++; $display("FAIL job_length got=%0d exp=%0d", done_abs, N + 2);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < N; i++) begin
            B[i] = 127;
            for (int j = 0; j < N; j++) A[i][j] = 127;
        end
        run_job(0, 100, 1'b0, -1);
        checks++;
        if (got_d[0] !== 127 || got_t[0] !== 16) begin
            failures++; $display("FAIL sat_pos got sat=%0d trunc=%0d exp=127/16", got_d[0], got_t[0]);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) A[i][j] = -128;
        run_job(0, 100, 1'b0, -1);
        checks++;
        if (got_d[N-1] !== -128) begin
            failures++; $display("FAIL sat_neg got=%0d exp=-128", got_d[N-1]);
        end
    endtask

    task automatic test_scaling;
        for (int i = 0; i < N; i++) begin
            B[i] = (i == 3) ? -32 : 1;
            for (int j = 0; j < N; j++) A[i][j] = 1;
        end
        run_job(0, 100, 1'b0, -1);
        for (int k = 0; k < N; k += 5) begin
            checks++;
            if (got_s[k] !== -2 || got_d[k] !== -17) begin
                failures++; $display("FAIL scale[%0d] got shift=%0d plain=%0d exp=-2/-17", k, got_s[k],
                                     got_d[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        randomize_job();
        run_job(2, 100, 1'b0, -1);
        for (int jb = 0; jb < 3; jb++) begin
            randomize_job();
            run_job(1, 80, 1'b0, -1);
        end
    endtask

    task automatic test_protocol;
        randomize_job();
        @(negedge clk);
        row_valid = 1'b1; row_data = ~'0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (row_ready !== 1'b0) begin
                failures++; $display("FAIL row_in_idle got=%b exp=0", row_ready);
            end
            @(negedge clk);
        end
        run_job(1, 90, 1'b1, -1);
    endtask

    task automatic test_reset_mid_job;
        randomize_job();
        run_job(0, 100, 1'b0, 6);
        randomize_job();
        run_job(1, 90, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_scaling();
        test_backpressure();
        test_protocol();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
